// File: rtl/bank_read_gather_if.sv
// Bank read-return bus: request side (valid, bank indices, flush, bank data) and
// the gathered lane-ordered result with its valid strobe and in-flight indicator.
interface bank_read_gather_if #(
    parameter int N_LANES = 8,
    parameter int MAPW    = 3,
    parameter int DW      = 12
);
    logic                    req_valid;
    logic [N_LANES*MAPW-1:0] BI_bus;
    logic                    flush;
    logic [N_LANES*DW-1:0]   bank_rdata_bus;
    logic [N_LANES*DW-1:0]   lane_rdata_bus;
    logic                    lane_valid;
    logic                    busy;

    modport master (
        output req_valid, BI_bus, flush, bank_rdata_bus,
        input  lane_rdata_bus, lane_valid, busy
    );

    modport slave (
        input  req_valid, BI_bus, flush, bank_rdata_bus,
        output lane_rdata_bus, lane_valid, busy
    );
endinterface

// File: rtl/bank_read_gather.sv
// Routes each bank's read data back to its requesting lane after RD_LAT cycles.
// Optional duplicate-bank-index detection is enabled by defining BI_CONFLICT_CHECK_EN.
module bank_read_gather #(
    parameter int N_LANES = 8,
    parameter int MAPW    = 3,
    parameter int DW      = 12,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    bank_read_gather_if.slave bus
`ifdef BI_CONFLICT_CHECK_EN
    ,
    output logic              conflict_err,
    output logic [7:0]        conflict_cnt,
    input  logic              err_clr
`endif
);
    localparam int BIW = N_LANES * MAPW;
    localparam int BW  = N_LANES * DW;

    logic           vld_p0 [RD_LAT];
    logic [BIW-1:0] bi_p0  [RD_LAT];
    logic [BW-1:0]  gathered;
    logic [BW-1:0]  lane_rdata_p1;
    logic           vld_p1;
    logic           busy_c;

    // Indices beyond the bank count select zero data.
    function automatic logic [DW-1:0] pick_bank(input logic [BW-1:0] data,
                                                input logic [MAPW-1:0] idx);
        logic [DW-1:0] r;
        r = '0;
        for (int j = 0; j < N_LANES; j++) begin
            if (int'(idx) == j) r = data[j*DW +: DW];
        end
        return r;
    endfunction

    // ---- p0: bank-index delay line matching the bank read latency ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld_p0[k] <= 1'b0;
                bi_p0[k]  <= '0;
            end
        end else begin
            vld_p0[0] <= bus.req_valid & ~bus.flush;
            bi_p0[0]  <= bus.BI_bus;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_p0[k] <= vld_p0[k-1] & ~bus.flush;
                bi_p0[k]  <= bi_p0[k-1];
            end
        end
    end

    always_comb begin
        gathered = '0;
        for (int i = 0; i < N_LANES; i++) begin
            gathered[i*DW +: DW] = pick_bank(bus.bank_rdata_bus, bi_p0[RD_LAT-1][i*MAPW +: MAPW]);
        end
    end

    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < RD_LAT; k++) busy_c = busy_c | vld_p0[k];
    end

    // ---- p1: registered lane-ordered result; data holds when not loading ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            lane_rdata_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0[RD_LAT-1] & ~bus.flush;
            if (vld_p0[RD_LAT-1] && !bus.flush) lane_rdata_p1 <= gathered;
        end
    end

    assign bus.lane_rdata_bus = lane_rdata_p1;
    assign bus.lane_valid     = vld_p1;
    assign bus.busy           = busy_c;

`ifdef BI_CONFLICT_CHECK_EN
    function automatic logic has_dup(input logic [BIW-1:0] bi);
        logic d;
        d = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            for (int j = i + 1; j < N_LANES; j++) begin
                if (bi[i*MAPW +: MAPW] == bi[j*MAPW +: MAPW]) d = 1'b1;
            end
        end
        return d;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_err <= 1'b0;
            conflict_cnt <= '0;
        end else if (err_clr) begin
            conflict_err <= 1'b0;
            conflict_cnt <= '0;
        end else if (bus.req_valid && !bus.flush && has_dup(bus.BI_bus)) begin
            conflict_err <= 1'b1;
            conflict_cnt <= sat_inc(conflict_cnt);
        end
    end
`endif
endmodule

// File: doc/bank_read_gather.md
Name: bank_read_gather

Overview:
- Return-path companion to the bank-request scatter in the multi-lane NTT datapath.
- The scatter steers each lane's request to its bank. This block routes each bank's read data back to the requesting lane.
- It delays each lane's bank index (BI) by the bank read latency, then gathers `bank_rdata` into lane order and registers the result with a valid strobe.
- Sits between the 2*`P` memory banks and the butterfly-unit operand inputs.

Parameters:
- N_LANES, 2*`P, number of lanes and number of banks (equal).
- MAPW, `MAP, bank-index width; 2^MAPW >= N_LANES.
- DW, 12, coefficient data width per lane/bank.
- RD_LAT, 1, bank read latency in cycles, from request to data on `bank_rdata_bus`; legal range 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  a read request was issued to the banks this cycle.
- BI_bus  in  N_LANES*MAPW  per-lane bank index, lane i at [i*MAPW +: MAPW]; same packing as the scatter input.
- flush  in  1  synchronous pipeline kill.
- bank_rdata_bus  in  N_LANES*DW  bank j read data at [j*DW +: DW]; valid RD_LAT cycles after the request.
- lane_rdata_bus  out  N_LANES*DW  gathered data, lane i at [i*DW +: DW].
- lane_valid  out  1  `lane_rdata_bus` holds a completed request.
- busy  out  1  at least one request is in flight in the delay line.

Behaviour:
- Delay line: RD_LAT stages, each holding {valid, BI vector}.
  - Stage 0 loads {`req_valid`, `BI_bus`} every cycle.
  - Stage k loads stage k-1.
  - BI is captured regardless of valid, but only acted on when valid.
- Gather: on the cycle stage RD_LAT-1 is valid, lane i selects `bank_rdata_bus[BI_d[i]]` and the result is registered into `lane_rdata_bus`.
- `lane_valid` is set from stage RD_LAT-1 valid on the same edge.
- Latency: request at edge t gives `lane_valid`=1 and data during cycle t+RD_LAT+1 (RD_LAT+1 edges).
- Throughput: one request per cycle; no backpressure; no stalls.
- When the output stage is not valid, `lane_rdata_bus` holds its previous value. `lane_valid` deasserts after one cycle unless a new result arrives.
- Out-of-range BI (value >= N_LANES, possible only when N_LANES is not a power of 2) selects zero data.
- Duplicate BI values across lanes are a scatter-side conflict. Each lane still receives its selected bank's data; no other effect unless the optional feature is enabled.
- `busy` = OR of all delay-stage valid bits. Combinational from registers; it excludes the output register.
- `flush`=1:
  - clears every delay-stage valid and `lane_valid` on the next edge;
  - a `req_valid` in the same cycle is dropped;
  - data registers keep their contents.
- Reset, effective immediately and asynchronously:
  - all stage valids 0, all BI registers 0;
  - `lane_rdata_bus`=0, `lane_valid`=0, `busy`=0.
  - Requests in flight at reset are lost. The first output after reset release comes only from a request issued after release.

Optional Feature:
- Macro: BI_CONFLICT_CHECK_EN.
- When defined, add these ports:
  - `conflict_err`  out  1  sticky flag.
  - `conflict_cnt`  out  8  saturating count.
  - `err_clr`  in  1  synchronous clear.
- Conflict check: on each edge where `req_valid`=1 and `flush`=0, if any two lanes carry equal BI, set `conflict_err` and increment `conflict_cnt`. The count saturates at 255.
- `err_clr` zeros both on the next edge; a conflict in the same cycle as `err_clr` is not recorded.
- Reset zeros both.
- When the macro is not defined, the ports, logic and registers are absent. Core behaviour is identical either way.

Test Plan:
- Identity: N_LANES=8, RD_LAT=1, BI=0..7, bank j data=100+j -> after 2 edges `lane_valid`=1 and lane i=100+i.
- Reversal and rotation: BI lane i=7-i, then next cycle BI lane i=(i+3)%8, with bank data changed each cycle -> two consecutive valid outputs, each matching the bank data of its own cycle.
- Back-to-back with RD_LAT=3: 10 consecutive requests with distinct patterns -> 10 consecutive `lane_valid` cycles starting at edge 4; `busy` high throughout and low 3 cycles after the last request.
- Flush: request at t, `flush` at t+1 with RD_LAT=2 -> no `lane_valid` for that request; a request at t+2 completes normally at t+5.
- Reset mid-flight: assert `rst` with 2 requests in flight -> outputs zero immediately; nothing emerges after release until a new request is issued.
- Conflict (macro on): BI={0,0,1,2,3,4,5,6} on 3 requests -> `conflict_err`=1, `conflict_cnt`=3; `err_clr` -> 0; 300 conflicts -> `conflict_cnt`=255.
